lut_access_ctrl: RTL and testbench
==================================

LUT_ACCESS_CTRL -- requirements
Module: lut_access_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- NUM_REQ, 2, number of read requesters.
- DATA_WIDTH, 32, coefficient width.
- DEPTH, 3584, coefficient words (14 segments x 256 bins).
- ADDR_WIDTH, 12, LUT address width.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester read request.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed read addresses, requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_ready  out  NUM_REQ  one-hot grant, combinational.
- rsp_valid  out  NUM_REQ  per-requester read-data strobe.
- rsp_data  out  DATA_WIDTH  read data, shared by all requesters.
- reload_start  in  1  request a full-table rewrite.
- wr_valid  in  1  reload word valid.
- wr_data  in  DATA_WIDTH  reload word.
- wr_ready  out  1  reload word accepted.
- reload_busy  out  1  reload in progress, covering DRAIN and RELOAD.
- reload_done  out  1  one-cycle pulse after the last word is written.
- lut_address  out  ADDR_WIDTH  to LUT address.
- lut_data  out  DATA_WIDTH  to LUT write data.
- lut_rden  out  1  to LUT read enable.
- lut_wren  out  1  to LUT write enable.
- lut_q  in  DATA_WIDTH  from LUT; valid 1 cycle after the address is sampled.

Function
REQ-003 The block SHALL share one single-port coefficient LUT between NUM_REQ read requesters and one reload writer.
REQ-004 Handshake: a read transfer SHALL occur on any cycle where req_valid[i] and req_ready[i] are both 1.
REQ-005 req_ready SHALL be one-hot or zero, and SHALL be all-zero outside state SERVE.
REQ-006 Arbitration SHALL be round-robin: the highest priority goes to the first valid requester at or after rr_ptr, and rr_ptr SHALL become granted index+1 (mod NUM_REQ) after each grant.
REQ-007 If the granted transfer is in cycle T, lut_address and lut_rden=1 SHALL be registered at T+1.
REQ-008 rsp_valid[i] SHALL be 1 at T+2, and rsp_data SHALL equal lut_q at T+2 (combinational pass-through). Latency is 2 cycles.
REQ-009 Full throughput SHALL be one read per cycle, back-to-back.
REQ-010 lut_rden SHALL be 0 on cycles with no granted transfer.
REQ-011 A req_addr value >= DEPTH SHALL be forwarded as DEPTH-1 (clamp).
REQ-012 States SHALL be SERVE, DRAIN and RELOAD.
REQ-013 SERVE SHALL go to DRAIN when reload_start=1. No grant SHALL be issued in the cycle reload_start is sampled.
REQ-014 DRAIN SHALL go to RELOAD once both in-flight read stages are empty, which takes at most 2 cycles.
REQ-015 In RELOAD, wr_ready SHALL be 1. Each accepted word SHALL register lut_wren=1, lut_address=wr_cnt and lut_data=wr_data on the next cycle, and wr_cnt SHALL then increment.
REQ-016 Acceptance of the word with wr_cnt=DEPTH-1 SHALL clear wr_cnt, pulse reload_done on the following cycle and return the FSM to SERVE.
REQ-017 lut_rden and lut_wren SHALL never be 1 in the same cycle.
REQ-018 reload_start SHALL be ignored while reload_busy=1.
REQ-019 wr_valid SHALL be ignored outside RELOAD.
REQ-020 wr_valid gaps in RELOAD SHALL stall wr_cnt without a timeout.

Reset
REQ-021 On rst_n=0, all of the following SHALL be cleared asynchronously: lut_address=0, lut_data=0, lut_rden=0, lut_wren=0, rsp_valid=0, reload_busy=0, reload_done=0, wr_cnt=0, rr_ptr=0 and in-flight tags; the state SHALL go to SERVE.
REQ-022 Reset during RELOAD SHALL abandon the reload; table contents are then undefined until a full reload completes.
REQ-023 Reset SHALL discard all in-flight reads, and no rsp_valid SHALL be produced for them.

Configuration
REQ-024 Macro LUT_RELOAD_EN defined SHALL compile in DRAIN/RELOAD, wr_cnt and the reload ports' behaviour.
REQ-025 Without LUT_RELOAD_EN:
- the FSM SHALL be permanently SERVE;
- wr_ready, lut_wren, reload_busy and reload_done SHALL be constant 0, and lut_data SHALL be constant 0;
- reload_start, wr_valid and wr_data SHALL be ignored;
- the port list SHALL be unchanged.

Verification
REQ-026 Single read: req_valid=01, req_addr[0]=0x005 at T -> lut_address=0x005 and lut_rden=1 at T+1; rsp_valid=01 and rsp_data=mem[5] at T+2.
REQ-027 Contention: req_valid=11 held for 4 cycles with rr_ptr=0 -> grants 01,10,01,10; each rsp_valid matches its grant, 2 cycles later.
REQ-028 Clamp: req_addr[1]=0xFFF -> lut_address=0xDFF (3583).
REQ-029 Reload (LUT_RELOAD_EN): reload_start with a read granted at T -> that read's rsp arrives; no grants during DRAIN; 3584 words of value addr^0xA5A5 are written to addresses 0..3583; reload_done pulses once; a subsequent read of 0x010 returns 0xA5B5.
REQ-030 Reset mid-reload: rst_n low after 100 words -> all outputs 0 and state SERVE; a new reload_start restarts writes at address 0.
REQ-031 Build without LUT_RELOAD_EN: reload_start and wr_valid toggled -> wr_ready, lut_wren, reload_busy and reload_done stay 0, and reads are unaffected.

Source files
------------

// File: rtl/lut_access_ctrl.sv
// Round-robin read arbiter sharing one single-port coefficient LUT among NUM_REQ readers.
// Define LUT_RELOAD_EN to build the DRAIN/RELOAD path that rewrites the whole table.
module lut_access_ctrl #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 3584,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  input  logic                          reload_start,
  input  logic                          wr_valid,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          wr_ready,
  output logic                          reload_busy,
  output logic                          reload_done,
  output logic [ADDR_WIDTH-1:0]         lut_address,
  output logic [DATA_WIDTH-1:0]         lut_data,
  output logic                          lut_rden,
  output logic                          lut_wren,
  input  logic [DATA_WIDTH-1:0]         lut_q
);
  // state  | meaning
  // SERVE  | arbitrating reads onto the LUT
  // DRAIN  | waiting for in-flight reads to retire
  // RELOAD | writing reload words at wr_cnt
  localparam logic [1:0] ST_SERVE = 2'd0;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [1:0]            state_q;
  logic                  serve_ok;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]      grant_idx, cand;
  logic [NUM_REQ-1:0]    grant;
  logic                  grant_any;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [ADDR_WIDTH-1:0] sel_addr, rd_addr;
  logic [ADDR_WIDTH-1:0] lut_address_q, lut_address_d;
  logic                  lut_rden_q;

  // Search starts at rr_ptr and wraps; the first valid requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    sel_addr  = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (serve_ok && !grant_any && req_valid[cand]) begin
        grant_any   = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
        sel_addr    = req_addr[int'(cand)*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign rd_addr = (32'(sel_addr) >= 32'(DEPTH)) ? LAST_ADDR : sel_addr;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
    rd_idx_d = grant_any ? grant_idx : rd_idx_q;
    rsp_valid_d = '0;
    if (lut_rden_q) begin
      rsp_valid_d[rd_idx_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      rd_idx_q      <= '0;
      rsp_valid_q   <= '0;
      lut_rden_q    <= 1'b0;
      lut_address_q <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      rd_idx_q      <= rd_idx_d;
      rsp_valid_q   <= rsp_valid_d;
      lut_rden_q    <= grant_any;
      lut_address_q <= lut_address_d;
    end
  end

  assign req_ready   = grant;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = lut_q;
  assign lut_address = lut_address_q;
  assign lut_rden    = lut_rden_q;

`ifdef LUT_RELOAD_EN
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_RELOAD = 2'd2;

  logic [1:0]            state_d;
  logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [DATA_WIDTH-1:0] lut_data_q;
  logic                  lut_wren_q, reload_done_q;
  logic                  wr_acc, wr_last;

  assign wr_acc   = (state_q == ST_RELOAD) && wr_valid;
  assign wr_last  = (wr_cnt_q == LAST_ADDR);
  assign serve_ok = (state_q == ST_SERVE) && !reload_start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SERVE:  if (reload_start) state_d = ST_DRAIN;
      ST_DRAIN:  if (!lut_rden_q && (rsp_valid_q == '0)) state_d = ST_RELOAD;
      ST_RELOAD: if (wr_acc && wr_last) state_d = ST_SERVE;
      default:   state_d = ST_SERVE;
    endcase
  end

  assign wr_cnt_d = wr_acc ? (wr_last ? '0 : wr_cnt_q + 1'b1) : wr_cnt_q;
  // Reads and writes never coincide: grants happen only in SERVE, writes only in RELOAD.
  assign lut_address_d = wr_acc ? wr_cnt_q : (grant_any ? rd_addr : lut_address_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_SERVE;
      wr_cnt_q      <= '0;
      lut_data_q    <= '0;
      lut_wren_q    <= 1'b0;
      reload_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      lut_wren_q    <= wr_acc;
      reload_done_q <= wr_acc && wr_last;
      if (wr_acc) lut_data_q <= wr_data;
    end
  end

  assign wr_ready    = (state_q == ST_RELOAD);
  assign reload_busy = (state_q != ST_SERVE);
  assign reload_done = reload_done_q;
  assign lut_wren    = lut_wren_q;
  assign lut_data    = lut_data_q;
`else
  logic unused_reload;

  assign state_q       = ST_SERVE;
  assign serve_ok      = (state_q == ST_SERVE);
  assign lut_address_d = grant_any ? rd_addr : lut_address_q;
  assign wr_ready      = 1'b0;
  assign reload_busy   = 1'b0;
  assign reload_done   = 1'b0;
  assign lut_wren      = 1'b0;
  assign lut_data      = '0;
  assign unused_reload = ^{reload_start, wr_valid, wr_data};
`endif

endmodule

// File: tb/tb_lut_access_ctrl.sv
// Self-checking bench for lut_access_ctrl: directed table, random reads against a
// behavioural model, reset discard, and reload sequences when LUT_RELOAD_EN is defined.
module tb_lut_access_ctrl;
  localparam int NUM_REQ = 2;
  localparam int DW      = 32;
  localparam int DEPTH   = 3584;
  localparam int AW      = 12;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ*AW-1:0] req_addr = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [DW-1:0]         rsp_data;
  logic                  reload_start = 1'b0;
  logic                  wr_valid = 1'b0;
  logic [DW-1:0]         wr_data = '0;
  logic                  wr_ready;
  logic                  reload_busy;
  logic                  reload_done;
  logic [AW-1:0]         lut_address;
  logic [DW-1:0]         lut_data;
  logic                  lut_rden;
  logic                  lut_wren;
  logic [DW-1:0]         lut_q = '0;

  always #5 clk = ~clk;

  lut_access_ctrl #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .reload_start(reload_start), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .reload_busy(reload_busy), .reload_done(reload_done),
    .lut_address(lut_address), .lut_data(lut_data), .lut_rden(lut_rden), .lut_wren(lut_wren),
    .lut_q(lut_q)
  );

  // Single-port LUT stand-in with one cycle of read latency.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (lut_wren) mem[lut_address] <= lut_data;
    if (lut_rden) lut_q <= mem[lut_address];
  end

  int checks = 0;
  int errors = 0;
  bit reloaded = 1'b0;
  int done_cnt = 0;

  // Reference model: round-robin pointer and a two-deep queue of expected reads.
  int rr = 0;
  bit p1_v, p2_v;
  int p1_idx, p2_idx, p1_addr, p2_addr;

  typedef struct {
    logic [1:0]  v;
    logic [11:0] a0;
    logic [11:0] a1;
    logic [1:0]  rdy;
    logic [11:0] addr;
  } vec_t;
  vec_t tbl [11];

  function automatic logic [31:0] init_val(input int a);
    return (32'(a) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] exp_val(input int a);
    if (reloaded) return 32'(a) ^ 32'h0000_A5A5;
    return init_val(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    rr = 0; p1_v = 1'b0; p2_v = 1'b0; p1_idx = 0; p2_idx = 0; p1_addr = 0; p2_addr = 0;
  endtask

  task automatic step(input logic [1:0] v, input logic [11:0] a0, input logic [11:0] a1,
                      input bit use_tbl, input logic [1:0] t_rdy, input logic [11:0] t_addr);
    int g;
    int sel;
    int addr;
    logic [1:0] er;
    @(negedge clk);
    chk("lut_rden", lut_rden, p1_v);
    if (p1_v) chk("lut_address", lut_address, p1_addr);
    chk("rsp_valid", rsp_valid, p2_v ? (2'b01 << p2_idx) : 2'b00);
    if (p2_v) chk("rsp_data", rsp_data, exp_val(p2_addr));
    chk("rden_wren_excl", lut_rden & lut_wren, 0);
`ifndef LUT_RELOAD_EN
    chk("reload_idle", {wr_ready, lut_wren, reload_busy, reload_done}, 0);
    chk("lut_data_zero", lut_data, 0);
    reload_start = 1'($urandom_range(0, 1));
    wr_valid     = 1'($urandom_range(0, 1));
    wr_data      = $urandom;
`endif
    req_valid = v;
    req_addr  = {a1, a0};
    #1;
    g = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (g < 0 && v[(rr + k) % NUM_REQ]) g = (rr + k) % NUM_REQ;
    end
    er   = (g < 0) ? 2'b00 : (2'b01 << g);
    sel  = (g == 1) ? int'(a1) : int'(a0);
    addr = (sel >= DEPTH) ? DEPTH - 1 : sel;
    if (use_tbl) begin
      chk("tbl_req_ready", req_ready, t_rdy);
      addr = int'(t_addr);
    end else begin
      chk("req_ready", req_ready, er);
    end
    p2_v = p1_v; p2_idx = p1_idx; p2_addr = p1_addr;
    p1_v = (g >= 0); p1_idx = g; p1_addr = addr;
    if (g >= 0) rr = (g + 1) % NUM_REQ;
  endtask

`ifdef LUT_RELOAD_EN
  always @(negedge clk) if (reload_done) done_cnt++;

  task automatic wait_wr_ready(input string name);
    int n = 0;
    while (n < 10) begin
      @(negedge clk);
      if (wr_ready) break;
      chk({name, "_no_grant"}, req_ready, 0);
      chk({name, "_no_wren"}, lut_wren, 0);
      n++;
    end
    if (!wr_ready) begin
      checks++; errors++;
      $display("FAIL %s: wr_ready never rose within 10 cycles", name);
    end
  endtask

  // Entered at a negedge where wr_ready is already 1; leaves one cycle after the last acceptance.
  task automatic write_words(input int n, input bit gaps);
    int  cnt = 0;
    bit  pend = 1'b0;
    int  paddr = 0;
    int  budget = 0;
    bit  wv;
    while (1) begin
      chk("wr_excl", lut_rden & lut_wren, 0);
      if (pend) begin
        chk("wr_wren", lut_wren, 1);
        chk("wr_addr", lut_address, paddr);
        chk("wr_data", lut_data, 32'(paddr) ^ 32'h0000_A5A5);
      end else begin
        chk("wr_idle", lut_wren, 0);
      end
      pend = 1'b0;
      if (cnt == n) break;
      if (budget > 20000) begin
        checks++; errors++;
        $display("FAIL write_budget: wrote %0d of %0d words", cnt, n);
        break;
      end
      wv = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      wr_valid = wv;
      wr_data  = 32'(cnt) ^ 32'h0000_A5A5;
      #1;
      chk("wr_ready", wr_ready, 1);
      if (wv) begin pend = 1'b1; paddr = cnt; cnt++; end
      budget++;
      @(negedge clk);
    end
    wr_valid = 1'b0;
  endtask
`endif

  initial begin
    for (int a = 0; a < DEPTH; a++) mem[a] = init_val(a);
    tbl[0]  = '{2'b11, 12'h100, 12'h200, 2'b01, 12'h100};
    tbl[1]  = '{2'b11, 12'h101, 12'h201, 2'b10, 12'h201};
    tbl[2]  = '{2'b11, 12'h102, 12'h202, 2'b01, 12'h102};
    tbl[3]  = '{2'b11, 12'h103, 12'h203, 2'b10, 12'h203};
    tbl[4]  = '{2'b01, 12'h005, 12'h000, 2'b01, 12'h005};
    tbl[5]  = '{2'b10, 12'h000, 12'hFFF, 2'b10, 12'hDFF};
    tbl[6]  = '{2'b00, 12'h000, 12'h000, 2'b00, 12'h000};
    tbl[7]  = '{2'b10, 12'h000, 12'hE00, 2'b10, 12'hDFF};
    tbl[8]  = '{2'b01, 12'hDFE, 12'h000, 2'b01, 12'hDFE};
    tbl[9]  = '{2'b01, 12'h123, 12'h000, 2'b01, 12'h123};
    tbl[10] = '{2'b10, 12'h000, 12'h7FF, 2'b10, 12'h7FF};

    model_reset();
    #12;
    chk("rst_outputs", {lut_address, lut_rden, lut_wren, rsp_valid, reload_busy, reload_done, wr_ready, req_ready}, 0);
    chk("rst_lut_data", lut_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) step(tbl[i].v, tbl[i].a0, tbl[i].a1, 1'b1, tbl[i].rdy, tbl[i].addr);
    repeat (2) step(2'b00, 12'h0, 12'h0, 1'b0, 2'b00, 12'h0);

    for (int i = 0; i < 300; i++)
      step(2'($urandom_range(0, 3)), 12'($urandom), 12'($urandom), 1'b0, 2'b00, 12'h0);
    repeat (2) step(2'b00, 12'h0, 12'h0, 1'b0, 2'b00, 12'h0);

    // Two reads in flight, then reset: neither may produce a response.
    step(2'b01, 12'h050, 12'h000, 1'b0, 2'b00, 12'h0);
    step(2'b10, 12'h000, 12'h060, 1'b0, 2'b00, 12'h0);
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    chk("rst_flight_rden", lut_rden, 0);
    chk("rst_flight_rsp", rsp_valid, 0);
    model_reset();
    #2 rst_n = 1'b1;
    repeat (3) step(2'b00, 12'h0, 12'h0, 1'b0, 2'b00, 12'h0);
    step(2'b11, 12'h033, 12'h044, 1'b0, 2'b00, 12'h0);
    repeat (2) step(2'b00, 12'h0, 12'h0, 1'b0, 2'b00, 12'h0);

`ifdef LUT_RELOAD_EN
    reload_start = 1'b0;
    wr_valid = 1'b0;
    step(2'b01, 12'h010, 12'h000, 1'b0, 2'b00, 12'h0);
    @(negedge clk);
    chk("rl_rden_inflight", lut_rden, 1);
    chk("rl_addr_inflight", lut_address, 12'h010);
    reload_start = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("rl_start_no_grant", req_ready, 0);
    @(negedge clk);
    reload_start = 1'b0;
    wr_valid = 1'b1;
    #1;
    chk("rl_busy_drain", reload_busy, 1);
    chk("rl_inflight_rsp", rsp_valid, 2'b01);
    chk("rl_inflight_data", rsp_data, init_val(12'h010));
    chk("rl_drain_no_grant", req_ready, 0);
    p1_v = 1'b0; p2_v = 1'b0;
    wait_wr_ready("drain");
    req_valid = 2'b00;
    done_cnt = 0;
    write_words(DEPTH, 1'b1);
    chk("rl_done_pulse", reload_done, 1);
    chk("rl_busy_after", reload_busy, 0);
    chk("rl_wr_ready_after", wr_ready, 0);
    reloaded = 1'b1;
    step(2'b01, 12'h010, 12'h000, 1'b0, 2'b00, 12'h0);
    repeat (2) step(2'b00, 12'h0, 12'h0, 1'b0, 2'b00, 12'h0);
    chk("rl_done_count", done_cnt, 1);
    for (int i = 0; i < 40; i++)
      step(2'($urandom_range(0, 3)), 12'($urandom), 12'($urandom), 1'b0, 2'b00, 12'h0);
    repeat (2) step(2'b00, 12'h0, 12'h0, 1'b0, 2'b00, 12'h0);

    // Reset after 100 words, then a fresh reload must start again at address 0.
    @(negedge clk);
    reload_start = 1'b1;
    @(negedge clk);
    reload_start = 1'b0;
    wait_wr_ready("drain2");
    write_words(100, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {lut_address, lut_rden, lut_wren, rsp_valid, reload_busy, reload_done, wr_ready, req_ready}, 0);
    chk("rst_mid_data", lut_data, 0);
    model_reset();
    #2 rst_n = 1'b1;
    @(negedge clk);
    reload_start = 1'b1;
    @(negedge clk);
    reload_start = 1'b0;
    wait_wr_ready("drain3");
    write_words(1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
